prv_trap_ctrl: RTL and testbench
================================

Name: prv_trap_ctrl

Overview:
- Machine-mode trap controller on the prv end of csr_prv_if; the CSR regfile sits on the other end.
- Prioritises synchronous exceptions and pending enabled interrupts from the pipeline.
- Writes mcause/mepc/mbadaddr/mstatus/mip through the *_rup/*_next strobes, then redirects fetch to the trap vector.
- Also performs mret by restoring mstatus and redirecting fetch to mepc.

Parameters:
- XLEN, 32, datapath width of the pc, address and CSR fields.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge
- nRST  input  1  asynchronous, active-low reset
- prv_if  interface  -  csr_prv_if.prv modport (rup strobes and next values out; mepc, mie, mip, mcause, mstatus in)
- mtvec  input  XLEN  trap base from CSR regfile
- mal_insn, fault_insn, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s  input  1 each  exception flags from the pipeline
- mret  input  1  mret retiring
- epc  input  XLEN  pc of the faulting/interrupted instruction
- badaddr  input  XLEN  faulting address
- ext_int, soft_int, timer_int  input  1 each  interrupt lines, level
- pipe_stall  input  1  pipeline not advancing; events are not taken while it is high
- fetch_ready  input  1  fetch accepts the redirect
- insert_pc  output  1  redirect valid
- priv_pc  output  XLEN  redirect target
- pipe_clear  output  1  flush the pipeline

Behaviour:
- Reset (nRST low, asynchronous):
  - state=IDLE.
  - All *_rup, *_next, insert_pc, pipe_clear, priv_pc = 0.
  - Interrupt edge registers = 0.
- Interrupt latching (any state): a rising edge on ext/soft/timer_int sets MEIP/MSIP/MTIP in mip_next=mip|edges and pulses mip_rup for 1 cycle. Levels that stay high do not re-pulse. Bits are cleared only by software CSR writes.
- Pending interrupt = mstatus.mie & mie.bit & mip.bit. Interrupt priority: ext(11) > soft(3) > timer(7).
- Exception priority and mcause code:
  - breakpoint 3
  - fault_insn 1
  - mal_insn 0
  - illegal_insn 2
  - env_m 11
  - mal_l 4
  - fault_l 5
  - mal_s 6
  - fault_s 7
- Exceptions beat interrupts; mcause bit XLEN-1 is set for interrupts only.
- FSM, IDLE:
  - If !pipe_stall and (exception or pending interrupt): latch cause/epc/badaddr -> TRAP.
  - Else if !pipe_stall and mret -> RET.
  - Exception and mret in the same cycle: exception wins and mret is dropped.
- FSM, TRAP (1 cycle):
  - Pulse mcause_rup, mepc_rup and mstatus_rup.
  - mbadaddr_rup is pulsed only for mal_*/fault_* causes.
  - mepc_next=epc.
  - mstatus_next: mpie=mie, mie=0, mpp=M.
  - pipe_clear=1.
  - -> VECTOR.
- FSM, VECTOR:
  - insert_pc=1, pipe_clear=1, priv_pc=mtvec (word aligned, low 2 bits forced 0).
  - Hold until fetch_ready, then -> IDLE.
- FSM, RET (1 cycle):
  - mstatus_rup=1; mstatus_next: mie=mpie, mpie=1.
  - -> RVEC: insert_pc=1, priv_pc=mepc, pipe_clear=1; hold until fetch_ready, then -> IDLE.
- New exceptions/mret are ignored outside IDLE; the pipeline is being flushed.
- Pending interrupts stay in mip and are taken on a later return to IDLE.
- Latency: event in IDLE cycle N -> CSR writes at N+1 -> insert_pc from N+2.
- Reset mid-trap aborts the sequence; no partial CSR strobe survives reset.

Optional Feature:
- Macro: PRV_VECTORED_INT_EN.
- Defined: interrupts vector to mtvec + 4*cause_code. Exceptions still vector to mtvec.
- Undefined: all traps vector to mtvec.

Decomposition:
- Shared package machine_mode_types_pkg holds:
  - the cause-code enum (exception and interrupt values above);
  - the FSM state enum;
  - the mip bit-index constants.
- csr_prv_if.prv modport gains output mbadaddr_next; the block drives it with the latched badaddr.
- One sub-module, prv_cause_prio: combinational priority encoder producing valid, is_int and code.

Test Plan:
- illegal_insn=1, epc=0x100, mtvec=0x200, mstatus.mie=1:
  - N+1: mcause_rup with mcause_next=2, mepc_next=0x100, mstatus_next.mie=0/mpie=1.
  - N+2: insert_pc=1, priv_pc=0x200; held 3 cycles with fetch_ready=0.
- mal_l=1 and breakpoint=1 same cycle, badaddr=0x33:
  - mcause_next=3.
  - mbadaddr_rup=0.
- timer_int rises with mie.MTIE=1, mstatus.mie=1:
  - mip_rup pulse, MTIP set.
  - Next IDLE cycle: mcause_next=0x80000007.
  - With PRV_VECTORED_INT_EN: priv_pc=mtvec+0x1C.
- mret with mepc=0x400, mstatus.mpie=1:
  - mstatus_next.mie=1.
  - insert_pc=1, priv_pc=0x400.
- env_m asserted while pipe_stall=1 for 4 cycles:
  - No strobes until stall drops.
  - Then mcause_next=11.
- nRST low during VECTOR:
  - insert_pc, pipe_clear and all rup go 0 immediately.
  - state IDLE after release.

Source files
------------

// File: rtl/prv_trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : machine_mode_types_pkg                                   |
// | Description: Shared machine-mode types: trap cause codes, trap FSM   |
// |              states, mip/mstatus bit positions, cause helper.        |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package machine_mode_types_pkg;

  // Synchronous exception cause codes (mcause with interrupt bit clear)
  typedef enum logic [3:0] {
    EXC_MAL_INSN     = 4'd0,
    EXC_FAULT_INSN   = 4'd1,
    EXC_ILLEGAL_INSN = 4'd2,
    EXC_BREAKPOINT   = 4'd3,
    EXC_MAL_L        = 4'd4,
    EXC_FAULT_L      = 4'd5,
    EXC_MAL_S        = 4'd6,
    EXC_FAULT_S      = 4'd7,
    EXC_ENV_M        = 4'd11
  } exc_cause_e;

  // Interrupt cause codes (mcause with interrupt bit set)
  typedef enum logic [3:0] {
    INT_SOFT_M  = 4'd3,
    INT_TIMER_M = 4'd7,
    INT_EXT_M   = 4'd11
  } int_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRAP   = 3'd1,
    ST_VECTOR = 3'd2,
    ST_RET    = 3'd3,
    ST_RVEC   = 3'd4
  } trap_state_e;

  // mip / mie bit positions
  localparam int c_meip_idx = 11;
  localparam int c_msip_idx = 3;
  localparam int c_mtip_idx = 7;

  // mstatus bit positions
  localparam int c_mstatus_mie_idx  = 3;
  localparam int c_mstatus_mpie_idx = 7;
  localparam int c_mstatus_mpp_lo   = 11;

  // Only address-related exceptions carry a meaningful faulting address
  function automatic logic has_badaddr(input logic is_int, input logic [3:0] code);
    logic r;
    r = 1'b0;
    if (!is_int) begin
      case (code)
        EXC_MAL_INSN, EXC_FAULT_INSN, EXC_MAL_L,
        EXC_FAULT_L, EXC_MAL_S, EXC_FAULT_S: r = 1'b1;
        default:                             r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prv_trap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : csr_prv_if                                               |
// | Description: Link between the trap controller (prv) and the CSR      |
// |              regfile (csr): update strobes, next values, live CSRs.  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface csr_prv_if #(
  parameter int XLEN = 32
);
  logic            mcause_rup;
  logic            mepc_rup;
  logic            mbadaddr_rup;
  logic            mstatus_rup;
  logic            mip_rup;
  logic [XLEN-1:0] mcause_next;
  logic [XLEN-1:0] mepc_next;
  logic [XLEN-1:0] mbadaddr_next;
  logic [XLEN-1:0] mstatus_next;
  logic [XLEN-1:0] mip_next;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mstatus;

  modport prv (
    output mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup, mip_rup,
    output mcause_next, mepc_next, mbadaddr_next, mstatus_next, mip_next,
    input  mepc, mie, mip, mcause, mstatus
  );

  modport csr (
    input  mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup, mip_rup,
    input  mcause_next, mepc_next, mbadaddr_next, mstatus_next, mip_next,
    output mepc, mie, mip, mcause, mstatus
  );
endinterface
`default_nettype wire

// File: rtl/prv_trap_ctrl_cause_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : prv_cause_prio                                           |
// | Description: Combinational trap priority encoder. Exceptions beat    |
// |              interrupts; interrupts ordered ext > soft > timer.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module prv_cause_prio
  import machine_mode_types_pkg::*;
(
  input  logic       i_mal_insn,
  input  logic       i_fault_insn,
  input  logic       i_illegal_insn,
  input  logic       i_breakpoint,
  input  logic       i_env_m,
  input  logic       i_mal_l,
  input  logic       i_fault_l,
  input  logic       i_mal_s,
  input  logic       i_fault_s,
  input  logic       i_ext_pend,
  input  logic       i_soft_pend,
  input  logic       i_timer_pend,
  output logic       o_valid,
  output logic       o_is_int,
  output logic [3:0] o_code
);

  // Fixed-priority selection of the winning trap cause
  always_comb begin
    o_valid  = 1'b1;
    o_is_int = 1'b0;
    o_code   = 4'd0;
    if (i_breakpoint)        o_code = EXC_BREAKPOINT;
    else if (i_fault_insn)   o_code = EXC_FAULT_INSN;
    else if (i_mal_insn)     o_code = EXC_MAL_INSN;
    else if (i_illegal_insn) o_code = EXC_ILLEGAL_INSN;
    else if (i_env_m)        o_code = EXC_ENV_M;
    else if (i_mal_l)        o_code = EXC_MAL_L;
    else if (i_fault_l)      o_code = EXC_FAULT_L;
    else if (i_mal_s)        o_code = EXC_MAL_S;
    else if (i_fault_s)      o_code = EXC_FAULT_S;
    else if (i_ext_pend)   begin o_is_int = 1'b1; o_code = INT_EXT_M;   end
    else if (i_soft_pend)  begin o_is_int = 1'b1; o_code = INT_SOFT_M;  end
    else if (i_timer_pend) begin o_is_int = 1'b1; o_code = INT_TIMER_M; end
    else                     o_valid = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/prv_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : prv_trap_ctrl                                            |
// | Description: Machine-mode trap controller. Takes exceptions and      |
// |              pending interrupts, writes the trap CSRs, redirects     |
// |              fetch to the trap vector; also performs mret.           |
// | Options    : PRV_VECTORED_INT_EN - interrupts vector to              |
// |              mtvec + 4*cause; exceptions always use mtvec.           |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module prv_trap_ctrl
  import machine_mode_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  csr_prv_if.prv          prv_if,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mal_insn,
  input  logic            fault_insn,
  input  logic            illegal_insn,
  input  logic            breakpoint,
  input  logic            env_m,
  input  logic            mal_l,
  input  logic            fault_l,
  input  logic            mal_s,
  input  logic            fault_s,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] badaddr,
  input  logic            ext_int,
  input  logic            soft_int,
  input  logic            timer_int,
  input  logic            pipe_stall,
  input  logic            fetch_ready,
  output logic            insert_pc,
  output logic [XLEN-1:0] priv_pc,
  output logic            pipe_clear
);

  trap_state_e     r_state;
  logic [2:0]      r_int_prev;      // {ext, soft, timer} seen last cycle
  logic [2:0]      w_int_lines;
  logic [2:0]      w_int_edges;
  logic [XLEN-1:0] w_edge_bits;
  logic            w_ext_pend;
  logic            w_soft_pend;
  logic            w_timer_pend;
  logic            w_ev_valid;
  logic            w_ev_is_int;
  logic [3:0]      w_ev_code;
  logic [XLEN-1:0] w_cause_word;
  logic [XLEN-1:0] w_trap_mstatus;
  logic [XLEN-1:0] w_ret_mstatus;
  logic [XLEN-1:0] w_vec_base;
  logic [XLEN-1:0] w_trap_pc;
  logic            w_unused;

  assign w_int_lines = {ext_int, soft_int, timer_int};
  assign w_int_edges = w_int_lines & ~r_int_prev;

  // Move each newly risen interrupt line onto its mip bit
  always_comb begin
    w_edge_bits              = '0;
    w_edge_bits[c_meip_idx]  = w_int_edges[2];
    w_edge_bits[c_msip_idx]  = w_int_edges[1];
    w_edge_bits[c_mtip_idx]  = w_int_edges[0];
  end

  assign w_ext_pend   = prv_if.mstatus[c_mstatus_mie_idx] & prv_if.mie[c_meip_idx] & prv_if.mip[c_meip_idx];
  assign w_soft_pend  = prv_if.mstatus[c_mstatus_mie_idx] & prv_if.mie[c_msip_idx] & prv_if.mip[c_msip_idx];
  assign w_timer_pend = prv_if.mstatus[c_mstatus_mie_idx] & prv_if.mie[c_mtip_idx] & prv_if.mip[c_mtip_idx];

  prv_cause_prio u_cause_prio (
    .i_mal_insn     (mal_insn),
    .i_fault_insn   (fault_insn),
    .i_illegal_insn (illegal_insn),
    .i_breakpoint   (breakpoint),
    .i_env_m        (env_m),
    .i_mal_l        (mal_l),
    .i_fault_l      (fault_l),
    .i_mal_s        (mal_s),
    .i_fault_s      (fault_s),
    .i_ext_pend     (w_ext_pend),
    .i_soft_pend    (w_soft_pend),
    .i_timer_pend   (w_timer_pend),
    .o_valid        (w_ev_valid),
    .o_is_int       (w_ev_is_int),
    .o_code         (w_ev_code)
  );

  assign w_cause_word = {w_ev_is_int, {(XLEN-5){1'b0}}, w_ev_code};

  // mstatus images for trap entry (stack mie, enter M) and for mret (unstack)
  always_comb begin
    w_trap_mstatus                            = prv_if.mstatus;
    w_trap_mstatus[c_mstatus_mpie_idx]        = prv_if.mstatus[c_mstatus_mie_idx];
    w_trap_mstatus[c_mstatus_mie_idx]         = 1'b0;
    w_trap_mstatus[c_mstatus_mpp_lo +: 2]     = 2'b11;
    w_ret_mstatus                             = prv_if.mstatus;
    w_ret_mstatus[c_mstatus_mie_idx]          = prv_if.mstatus[c_mstatus_mpie_idx];
    w_ret_mstatus[c_mstatus_mpie_idx]         = 1'b1;
  end

  assign w_vec_base = {mtvec[XLEN-1:2], 2'b00};

  // Trap target is resolved in TRAP from the cause already latched in mcause_next
`ifdef PRV_VECTORED_INT_EN
  assign w_trap_pc = prv_if.mcause_next[XLEN-1]
                   ? (w_vec_base + {prv_if.mcause_next[XLEN-3:0], 2'b00})
                   : w_vec_base;
`else
  assign w_trap_pc = w_vec_base;
`endif

  assign w_unused = ^{prv_if.mcause, prv_if.mstatus, prv_if.mie, prv_if.mip, mtvec[1:0]};

  // Trap/return sequencer with interrupt edge latching; all outputs registered
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state              <= ST_IDLE;
      r_int_prev           <= '0;
      prv_if.mcause_rup    <= 1'b0;
      prv_if.mepc_rup      <= 1'b0;
      prv_if.mbadaddr_rup  <= 1'b0;
      prv_if.mstatus_rup   <= 1'b0;
      prv_if.mip_rup       <= 1'b0;
      prv_if.mcause_next   <= '0;
      prv_if.mepc_next     <= '0;
      prv_if.mbadaddr_next <= '0;
      prv_if.mstatus_next  <= '0;
      prv_if.mip_next      <= '0;
      insert_pc            <= 1'b0;
      pipe_clear           <= 1'b0;
      priv_pc              <= '0;
    end else begin
      r_int_prev          <= w_int_lines;
      prv_if.mip_rup      <= |w_int_edges;
      if (|w_int_edges) begin
        prv_if.mip_next <= prv_if.mip | w_edge_bits;
      end
      prv_if.mcause_rup   <= 1'b0;
      prv_if.mepc_rup     <= 1'b0;
      prv_if.mbadaddr_rup <= 1'b0;
      prv_if.mstatus_rup  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!pipe_stall && w_ev_valid) begin
            r_state              <= ST_TRAP;
            prv_if.mcause_rup    <= 1'b1;
            prv_if.mepc_rup      <= 1'b1;
            prv_if.mstatus_rup   <= 1'b1;
            prv_if.mbadaddr_rup  <= has_badaddr(w_ev_is_int, w_ev_code);
            prv_if.mcause_next   <= w_cause_word;
            prv_if.mepc_next     <= epc;
            prv_if.mbadaddr_next <= badaddr;
            prv_if.mstatus_next  <= w_trap_mstatus;
            pipe_clear           <= 1'b1;
          end else if (!pipe_stall && mret) begin
            r_state             <= ST_RET;
            prv_if.mstatus_rup  <= 1'b1;
            prv_if.mstatus_next <= w_ret_mstatus;
          end
        end
        ST_TRAP: begin
          r_state    <= ST_VECTOR;
          insert_pc  <= 1'b1;
          pipe_clear <= 1'b1;
          priv_pc    <= w_trap_pc;
        end
        ST_RET: begin
          r_state    <= ST_RVEC;
          insert_pc  <= 1'b1;
          pipe_clear <= 1'b1;
          priv_pc    <= prv_if.mepc;
        end
        ST_VECTOR, ST_RVEC: begin
          if (fetch_ready) begin
            r_state    <= ST_IDLE;
            insert_pc  <= 1'b0;
            pipe_clear <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          insert_pc  <= 1'b0;
          pipe_clear <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prv_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_prv_trap_ctrl                                         |
// | Description: Self-checking bench for prv_trap_ctrl: directed cases   |
// |              with literal expectations plus randomized traffic       |
// |              against a cycle-level behavioural model.                |
// | Options    : PRV_VECTORED_INT_EN - interrupt target mtvec + 4*cause. |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_prv_trap_ctrl;
  localparam int XLEN = 32;

  logic        CLK  = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] mtvec = '0, epc = '0, badaddr = '0;
  logic        mal_insn = 1'b0, fault_insn = 1'b0, illegal_insn = 1'b0, breakpoint = 1'b0;
  logic        env_m = 1'b0, mal_l = 1'b0, fault_l = 1'b0, mal_s = 1'b0, fault_s = 1'b0;
  logic        mret = 1'b0, ext_int = 1'b0, soft_int = 1'b0, timer_int = 1'b0;
  logic        pipe_stall = 1'b0, fetch_ready = 1'b0;
  logic        insert_pc, pipe_clear;
  logic [31:0] priv_pc;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  csr_prv_if #(.XLEN(XLEN)) prv_if ();

  prv_trap_ctrl #(.XLEN(XLEN)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .prv_if       (prv_if),
    .mtvec        (mtvec),
    .mal_insn     (mal_insn),
    .fault_insn   (fault_insn),
    .illegal_insn (illegal_insn),
    .breakpoint   (breakpoint),
    .env_m        (env_m),
    .mal_l        (mal_l),
    .fault_l      (fault_l),
    .mal_s        (mal_s),
    .fault_s      (fault_s),
    .mret         (mret),
    .epc          (epc),
    .badaddr      (badaddr),
    .ext_int      (ext_int),
    .soft_int     (soft_int),
    .timer_int    (timer_int),
    .pipe_stall   (pipe_stall),
    .fetch_ready  (fetch_ready),
    .insert_pc    (insert_pc),
    .priv_pc      (priv_pc),
    .pipe_clear   (pipe_clear)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Modes: 0 = accepting events, 1 = CSR write cycle, 2 = redirect held until fetch_ready
  int          m_mode = 0;
  bit          m_trap = 1'b0, m_is_int = 1'b0, m_found = 1'b0;
  int          m_code = 0;
  logic [31:0] m_new = '0;
  int          exc_code [9] = '{3, 1, 0, 2, 11, 4, 5, 6, 7};
  logic        exc_flag [9];
  int          irq_code [3] = '{11, 3, 7};
  logic        irq_line [3];
  logic        irq_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic        x_insert = 1'b0, x_clear = 1'b0;
  logic        x_mcause_rup = 1'b0, x_mepc_rup = 1'b0, x_mbad_rup = 1'b0, x_mstatus_rup = 1'b0, x_mip_rup = 1'b0;
  logic [31:0] x_mcause = '0, x_mepc = '0, x_mbad = '0, x_mstatus = '0, x_mip = '0, x_pc = '0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_mode = 0;
      irq_prev = '{1'b0, 1'b0, 1'b0};
      x_insert = 0; x_clear = 0; x_pc = 0;
      x_mcause_rup = 0; x_mepc_rup = 0; x_mbad_rup = 0; x_mstatus_rup = 0; x_mip_rup = 0;
      x_mcause = 0; x_mepc = 0; x_mbad = 0; x_mstatus = 0; x_mip = 0;
    end else begin
      // interrupt line rising edges become new mip bits
      irq_line = '{ext_int, soft_int, timer_int};
      m_new = 0;
      for (int i = 0; i < 3; i++) if (irq_line[i] && !irq_prev[i]) m_new = m_new | (32'd1 << irq_code[i]);
      irq_prev = irq_line;
      x_mip_rup = (m_new != 0);
      if (x_mip_rup) x_mip = prv_if.mip | m_new;
      x_mcause_rup = 0; x_mepc_rup = 0; x_mbad_rup = 0; x_mstatus_rup = 0;
      if (m_mode == 0) begin
        if (!pipe_stall) begin
          exc_flag = '{breakpoint, fault_insn, mal_insn, illegal_insn, env_m, mal_l, fault_l, mal_s, fault_s};
          m_found = 0;
          for (int i = 0; i < 9; i++)
            if (!m_found && exc_flag[i]) begin m_found = 1; m_is_int = 0; m_code = exc_code[i]; end
          for (int i = 0; i < 3; i++)
            if (!m_found && prv_if.mstatus[3] && prv_if.mie[irq_code[i]] && prv_if.mip[irq_code[i]]) begin
              m_found = 1; m_is_int = 1; m_code = irq_code[i];
            end
          if (m_found) begin
            m_mode = 1; m_trap = 1;
            x_mcause_rup = 1; x_mepc_rup = 1; x_mstatus_rup = 1;
            x_mcause  = (m_is_int ? 32'h8000_0000 : 32'h0) + 32'(m_code);
            x_mepc    = epc;
            x_mbad    = badaddr;
            x_mbad_rup = !m_is_int && (m_code inside {0, 1, 4, 5, 6, 7});
            x_mstatus = (prv_if.mstatus & ~32'h0000_1888) | (32'(prv_if.mstatus[3]) << 7) | 32'h0000_1800;
            x_clear   = 1;
          end else if (mret) begin
            m_mode = 1; m_trap = 0;
            x_mstatus_rup = 1;
            x_mstatus = (prv_if.mstatus & ~32'h0000_0088) | (32'(prv_if.mstatus[7]) << 3) | 32'h0000_0080;
          end
        end
      end else if (m_mode == 1) begin
        m_mode = 2; x_insert = 1; x_clear = 1;
        if (m_trap) begin
          x_pc = mtvec & ~32'h3;
`ifdef PRV_VECTORED_INT_EN
          if (m_is_int) x_pc = x_pc + 32'(4 * m_code);
`endif
        end else begin
          x_pc = prv_if.mepc;
        end
      end else begin
        if (fetch_ready) begin m_mode = 0; x_insert = 0; x_clear = 0; end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("insert_pc", insert_pc, x_insert);
      chk("pipe_clear", pipe_clear, x_clear);
      chk("priv_pc", priv_pc, x_pc);
      chk("mcause_rup", prv_if.mcause_rup, x_mcause_rup);
      chk("mepc_rup", prv_if.mepc_rup, x_mepc_rup);
      chk("mbadaddr_rup", prv_if.mbadaddr_rup, x_mbad_rup);
      chk("mstatus_rup", prv_if.mstatus_rup, x_mstatus_rup);
      chk("mip_rup", prv_if.mip_rup, x_mip_rup);
      if (x_mcause_rup) begin
        chk("mcause_next", prv_if.mcause_next, x_mcause);
        chk("mepc_next", prv_if.mepc_next, x_mepc);
        chk("mbadaddr_next", prv_if.mbadaddr_next, x_mbad);
      end
      if (x_mstatus_rup) chk("mstatus_next", prv_if.mstatus_next, x_mstatus);
      if (x_mip_rup)     chk("mip_next", prv_if.mip_next, x_mip);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic clear_events();
    mal_insn = 0; fault_insn = 0; illegal_insn = 0; breakpoint = 0; env_m = 0;
    mal_l = 0; fault_l = 0; mal_s = 0; fault_s = 0; mret = 0; pipe_stall = 0;
  endtask

  task automatic chk_all_strobes_zero(input string tag);
    chk({tag, "_mcause_rup"}, prv_if.mcause_rup, 0);
    chk({tag, "_mepc_rup"}, prv_if.mepc_rup, 0);
    chk({tag, "_mbadaddr_rup"}, prv_if.mbadaddr_rup, 0);
    chk({tag, "_mstatus_rup"}, prv_if.mstatus_rup, 0);
    chk({tag, "_mip_rup"}, prv_if.mip_rup, 0);
    chk({tag, "_insert_pc"}, insert_pc, 0);
    chk({tag, "_pipe_clear"}, pipe_clear, 0);
    chk({tag, "_priv_pc"}, priv_pc, 0);
  endtask

  initial begin
    prv_if.mepc = 0; prv_if.mie = 0; prv_if.mip = 0; prv_if.mcause = 0; prv_if.mstatus = 0;
    repeat (3) tick();
    chk_all_strobes_zero("reset");
    chk("reset_mcause_next", prv_if.mcause_next, 0);
    chk("reset_mstatus_next", prv_if.mstatus_next, 0);
    nRST = 1;
    cmp_en = 1;
    tick();

    // illegal instruction, redirect held while fetch not ready
    mtvec = 32'h200; prv_if.mstatus = 32'h8; fetch_ready = 0;
    illegal_insn = 1; epc = 32'h100;
    tick();
    clear_events();
    chk("ill_mcause_rup", prv_if.mcause_rup, 1);
    chk("ill_mcause_next", prv_if.mcause_next, 32'h2);
    chk("ill_mepc_next", prv_if.mepc_next, 32'h100);
    chk("ill_mstatus_next", prv_if.mstatus_next, 32'h1880);
    chk("ill_insert_early", insert_pc, 0);
    tick();
    chk("ill_insert_pc", insert_pc, 1);
    chk("ill_priv_pc", priv_pc, 32'h200);
    tick(); chk("ill_hold2", insert_pc, 1);
    tick(); chk("ill_hold3", insert_pc, 1);
    fetch_ready = 1;
    tick();
    chk("ill_release", insert_pc, 0);

    // breakpoint outranks mal_l; no badaddr write
    mal_l = 1; breakpoint = 1; badaddr = 32'h33;
    tick();
    clear_events();
    chk("bp_mcause_next", prv_if.mcause_next, 32'h3);
    chk("bp_mbadaddr_rup", prv_if.mbadaddr_rup, 0);
    repeat (2) tick();

    // timer interrupt: latch into mip, then take it
    prv_if.mie = 32'h80; prv_if.mstatus = 32'h8; timer_int = 1;
    tick();
    chk("tim_mip_rup", prv_if.mip_rup, 1);
    chk("tim_mip_next", prv_if.mip_next, 32'h80);
    prv_if.mip = 32'h80;
    tick();
    chk("tim_no_repulse", prv_if.mip_rup, 0);
    chk("tim_mcause_next", prv_if.mcause_next, 32'h8000_0007);
    prv_if.mip = 0;
    tick();
`ifdef PRV_VECTORED_INT_EN
    chk("tim_priv_pc", priv_pc, 32'h21C);
`else
    chk("tim_priv_pc", priv_pc, 32'h200);
`endif
    tick();
    timer_int = 0; prv_if.mie = 0;

    // mret restores mie from mpie and returns to mepc
    prv_if.mstatus = 32'h80; prv_if.mepc = 32'h400; mret = 1;
    tick();
    clear_events();
    chk("ret_mstatus_rup", prv_if.mstatus_rup, 1);
    chk("ret_mstatus_next", prv_if.mstatus_next, 32'h88);
    chk("ret_no_mcause", prv_if.mcause_rup, 0);
    tick();
    chk("ret_insert_pc", insert_pc, 1);
    chk("ret_priv_pc", priv_pc, 32'h400);
    tick();

    // ecall held off by stall
    prv_if.mstatus = 0; env_m = 1; pipe_stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_mcause_rup", prv_if.mcause_rup, 0);
    end
    pipe_stall = 0;
    tick();
    clear_events();
    chk("stall_mcause_next", prv_if.mcause_next, 32'd11);
    repeat (2) tick();

    // reset while redirect pending
    fetch_ready = 0; illegal_insn = 1;
    tick();
    clear_events();
    tick();
    chk("rst_pre_insert", insert_pc, 1);
    #1 nRST = 0;
    #1 chk_all_strobes_zero("rst_mid");
    tick(); tick();
    nRST = 1; fetch_ready = 1; env_m = 1;
    tick();
    clear_events();
    chk("rst_after_mcause_rup", prv_if.mcause_rup, 1);
    chk("rst_after_mcause_next", prv_if.mcause_next, 32'd11);
    repeat (2) tick();

    // randomized traffic, checked cycle by cycle against the model
    for (int b = 0; b < 6; b++) begin
      clear_events(); prv_if.mstatus = 0; fetch_ready = 1;
      repeat (6) tick();
      mtvec = $urandom; prv_if.mepc = $urandom;
      for (int c = 0; c < 250; c++) begin
        tick();
        breakpoint   = ($urandom_range(0, 31) == 0);
        fault_insn   = ($urandom_range(0, 31) == 0);
        mal_insn     = ($urandom_range(0, 31) == 0);
        illegal_insn = ($urandom_range(0, 31) == 0);
        env_m        = ($urandom_range(0, 31) == 0);
        mal_l        = ($urandom_range(0, 31) == 0);
        fault_l      = ($urandom_range(0, 31) == 0);
        mal_s        = ($urandom_range(0, 31) == 0);
        fault_s      = ($urandom_range(0, 31) == 0);
        mret         = ($urandom_range(0, 15) == 0);
        pipe_stall   = ($urandom_range(0, 3) == 0);
        fetch_ready  = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 7) == 0) ext_int   = ~ext_int;
        if ($urandom_range(0, 7) == 0) soft_int  = ~soft_int;
        if ($urandom_range(0, 7) == 0) timer_int = ~timer_int;
        epc = $urandom; badaddr = $urandom;
        prv_if.mie = $urandom; prv_if.mip = $urandom;
        prv_if.mstatus = ($urandom & ~32'h8) | (($urandom_range(0, 3) == 0) ? 32'h8 : 32'h0);
      end
    end

    clear_events();
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
